// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared ROB allocation types and constants used by the rename-side ROB id allocator.
package rob_alloc_ctrl_pkg;

    localparam int ROB_DEPTH_DFLT    = 64;
    localparam int ROB_WIDTH_DFLT    = $clog2(ROB_DEPTH_DFLT);
    // Free entries needed for ready, so ready never looks at the request pattern
    localparam int ROB_ALLOC_RESERVE = 2;

    typedef logic [ROB_WIDTH_DFLT-1:0] rob_id_t;
    typedef logic [ROB_WIDTH_DFLT:0]   rob_cnt_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } rob_ctrl_state_e;

endpackage

// File: rtl/rob_alloc_ctrl.sv
// ROB id allocator: hands out up to two ids per cycle, tracks head/tail/count,
// and sequences flush recovery before allocation resumes.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int ROB_DEPTH      = ROB_DEPTH_DFLT,
    parameter int ROB_WIDTH      = $clog2(ROB_DEPTH),
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      alloc_valid_i,
    input  logic [1:0]                alloc_req_i,
    output logic                      alloc_ready_o,
    output logic [1:0]                alloc_fire_o,
    output logic [1:0][ROB_WIDTH-1:0] alloc_rob_id_o,
    input  logic [1:0]                retire_i,
    input  logic                      flush_i,
    output logic                      flush_ack_o,
    output logic [ROB_WIDTH-1:0]      head_o,
    output logic [ROB_WIDTH-1:0]      tail_o,
    output logic [ROB_WIDTH:0]        count_o,
    output logic                      err_o
);

    localparam int CNT_W = ROB_WIDTH + 1;
    localparam int RC_W  = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

    rob_ctrl_state_e state_q, state_d;
    logic [RC_W-1:0]      rc_q, rc_d;
    logic [ROB_WIDTH-1:0] head_q, tail_q, tail_nx;
    logic [CNT_W-1:0]     count_q, n_fire, n_ret;
    logic                 err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        flush_ack_o = 1'b0;
        case (state_q)
            RUN: begin
                if (flush_i) state_d = FLUSH;
            end
            FLUSH: begin
                if (!flush_i) begin
                    state_d = RECOVER;
                    rc_d    = RC_W'(RECOVER_CYCLES - 1);
                end
            end
            RECOVER: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (rc_q == '0) begin
                    flush_ack_o = 1'b1;
                    state_d     = RUN;
                end else begin
                    rc_d = rc_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign alloc_ready_o = (state_q == RUN) && !flush_i &&
                           (count_q <= CNT_W'(ROB_DEPTH - ROB_ALLOC_RESERVE));
    assign alloc_fire_o  = alloc_req_i & {2{alloc_valid_i & alloc_ready_o}};

    // Slot1 takes tail only when slot0 does not consume it
    assign alloc_rob_id_o[0] = tail_q;
    assign alloc_rob_id_o[1] = tail_q + ROB_WIDTH'(alloc_req_i[0]);

    assign n_fire  = CNT_W'(alloc_fire_o[0]) + CNT_W'(alloc_fire_o[1]);
    assign n_ret   = CNT_W'(retire_i[0]) + CNT_W'(retire_i[1]);
    assign tail_nx = tail_q + n_fire[ROB_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q != RUN || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (n_ret > count_q + n_fire) begin
            // Underflow: drop to empty at the post-allocation tail
            err_q   <= 1'b1;
            head_q  <= tail_nx;
            tail_q  <= tail_nx;
            count_q <= '0;
        end else begin
            head_q  <= head_q + n_ret[ROB_WIDTH-1:0];
            tail_q  <= tail_nx;
            count_q <= count_q + n_fire - n_ret;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Scoreboard bench for rob_alloc_ctrl: stimulus queues expected allocations and
// ack cycles, a negedge monitor compares them whenever the DUT fires or acks.
module tb_rob_alloc_ctrl;
    import rob_alloc_ctrl_pkg::*;

    logic           clk, rst_n;
    logic           alloc_valid_i, alloc_ready_o, flush_i, flush_ack_o, err_o;
    logic [1:0]     alloc_req_i, alloc_fire_o, retire_i;
    logic [1:0][5:0] alloc_rob_id_o;
    rob_id_t        head_o, tail_o;
    rob_cnt_t       count_o;

    rob_alloc_ctrl #(.ROB_DEPTH(64), .RECOVER_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid_i(alloc_valid_i), .alloc_req_i(alloc_req_i),
        .alloc_ready_o(alloc_ready_o), .alloc_fire_o(alloc_fire_o),
        .alloc_rob_id_o(alloc_rob_id_o), .retire_i(retire_i),
        .flush_i(flush_i), .flush_ack_o(flush_ack_o),
        .head_o(head_o), .tail_o(tail_o), .count_o(count_o), .err_o(err_o)
    );

    typedef struct {
        logic [1:0] fire;
        int         id0;
        int         id1;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   errs = 0;
    int   checks = 0;
    int   cyc_n = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (alloc_fire_o != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL alloc_unexpected: fire=%b ids=(%0d,%0d) with nothing expected",
                             alloc_fire_o, alloc_rob_id_o[0], alloc_rob_id_o[1]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (alloc_fire_o != e.fire ||
                        (e.fire[0] && int'(alloc_rob_id_o[0]) != e.id0) ||
                        (e.fire[1] && int'(alloc_rob_id_o[1]) != e.id1)) begin
                        errs++;
                        $display("FAIL alloc: got fire=%b ids=(%0d,%0d) expected fire=%b ids=(%0d,%0d)",
                                 alloc_fire_o, alloc_rob_id_o[0], alloc_rob_id_o[1],
                                 e.fire, e.id0, e.id1);
                    end
                end
            end
            begin
                bit exp_ack;
                exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc_n);
                if (flush_ack_o || exp_ack) begin
                    checks++;
                    if (flush_ack_o !== exp_ack) begin
                        errs++;
                        $display("FAIL flush_ack: got %b expected %b at cycle %0d",
                                 flush_ack_o, exp_ack, cyc_n);
                    end
                    if (exp_ack) void'(ack_q.pop_front());
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; expectations are queued before the edge that samples them
    task automatic step(input logic v, input logic [1:0] rq, input logic [1:0] rt,
                        input logic fl, input logic [1:0] ef, input int i0, input int i1,
                        input bit ea);
        exp_t e;
        alloc_valid_i = v;
        alloc_req_i   = rq;
        retire_i      = rt;
        flush_i       = fl;
        if (ef != 2'b00) begin
            e.fire = ef; e.id0 = i0; e.id1 = i1;
            exp_q.push_back(e);
        end
        if (ea) ack_q.push_back(cyc_n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; alloc_valid_i = 1'b0; alloc_req_i = 2'b00;
        retire_i = 2'b00; flush_i = 1'b0;
        #12;
        chk("rst_head", head_o, 0);
        chk("rst_tail", tail_o, 0);
        chk("rst_count", count_o, 0);
        chk("rst_ack", flush_ack_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_ready", alloc_ready_o, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic dual allocation
        step(1, 2'b11, 2'b00, 0, 2'b11, 0, 1, 0);
        step(1, 2'b11, 2'b00, 0, 2'b11, 2, 3, 0);
        step(1, 2'b11, 2'b00, 0, 2'b11, 4, 5, 0);
        chk("basic_tail", tail_o, 6);
        chk("basic_count", count_o, 6);
        chk("basic_ack", flush_ack_o, 0);

        // Fill to 62, then to 64
        for (int k = 0; k < 28; k++) step(1, 2'b11, 2'b00, 0, 2'b11, 6 + 2*k, 7 + 2*k, 0);
        chk("fill62_count", count_o, 62);
        chk("fill62_ready", alloc_ready_o, 1);
        step(1, 2'b11, 2'b00, 0, 2'b11, 62, 63, 0);
        chk("full_count", count_o, 64);
        chk("full_tail", tail_o, 0);
        chk("full_ready", alloc_ready_o, 0);
        step(1, 2'b01, 2'b00, 0, 2'b00, 0, 0, 0);
        chk("full_hold_count", count_o, 64);
        step(1, 2'b01, 2'b01, 0, 2'b00, 0, 0, 0);
        chk("c63_count", count_o, 63);
        chk("c63_ready", alloc_ready_o, 0);
        step(1, 2'b01, 2'b01, 0, 2'b00, 0, 0, 0);
        chk("c62_count", count_o, 62);
        chk("c62_head", head_o, 2);
        chk("c62_ready", alloc_ready_o, 1);

        // Async reset, then build the wrap case: tail=63, head=62, count=1
        alloc_valid_i = 1'b0; alloc_req_i = 2'b00; retire_i = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_count", count_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 31; k++) step(1, 2'b11, 2'b00, 0, 2'b11, 2*k, 2*k + 1, 0);
        step(1, 2'b01, 2'b00, 0, 2'b01, 62, 0, 0);
        for (int k = 0; k < 31; k++) step(0, 2'b00, 2'b11, 0, 2'b00, 0, 0, 0);
        chk("wrap_pre_head", head_o, 62);
        chk("wrap_pre_tail", tail_o, 63);
        chk("wrap_pre_count", count_o, 1);
        step(1, 2'b11, 2'b00, 0, 2'b11, 63, 0, 0);
        chk("wrap_tail", tail_o, 1);
        chk("wrap_count", count_o, 3);

        // Slot1-only request takes tail; then simultaneous alloc+retire
        step(1, 2'b10, 2'b00, 0, 2'b10, 0, 1, 0);
        chk("s1_count", count_o, 4);
        step(1, 2'b11, 2'b11, 0, 2'b11, 2, 3, 0);
        chk("sim_count", count_o, 4);
        chk("sim_head", head_o, 0);
        chk("sim_tail", tail_o, 4);
        step(0, 2'b00, 2'b11, 0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 2'b11, 0, 2'b00, 0, 0, 0);
        chk("drain_count", count_o, 0);
        chk("drain_err", err_o, 0);
        step(0, 2'b00, 2'b11, 0, 2'b00, 0, 0, 0);
        chk("uflow_err", err_o, 1);
        chk("uflow_count", count_o, 0);
        chk("uflow_head", head_o, 4);

        // Flush with valid traffic held high
        step(1, 2'b11, 2'b00, 1, 2'b00, 0, 0, 0);
        chk("flush_tail", tail_o, 0);
        chk("flush_count", count_o, 0);
        chk("flush_ready", alloc_ready_o, 0);
        step(1, 2'b11, 2'b11, 1, 2'b00, 0, 0, 0);
        step(1, 2'b11, 2'b00, 1, 2'b00, 0, 0, 0);
        step(1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0);
        chk("rec1_ready", alloc_ready_o, 0);
        step(1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 0);
        step(1, 2'b11, 2'b00, 0, 2'b00, 0, 0, 1);
        chk("post_ack_ready", alloc_ready_o, 1);
        chk("post_ack_pulse", flush_ack_o, 0);
        chk("err_sticky", err_o, 1);
        step(1, 2'b11, 2'b00, 0, 2'b11, 0, 1, 0);

        // Reset in the middle of recovery: no ack, back to RUN
        step(0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 0);
        step(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_err", err_o, 0);
        chk("mid_rst_ack", flush_ack_o, 0);
        chk("mid_rst_tail", tail_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("mid_rst_ready", alloc_ready_o, 1);
        step(1, 2'b11, 2'b00, 0, 2'b11, 0, 1, 0);
        step(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
        step(0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 0);
        chk("final_tail", tail_o, 2);
        chk("alloc_q_drained", exp_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
